// File: rtl/card_select_ctrl.sv
`timescale 1ns/1ps
// card_select_ctrl
// Cursor, pick, show and resolve control for a 6x6 card-matching game.
// The player moves a cursor, turns up two cards, sees them for SHOW_CYCLES
// cycles, and the pair is then either locked as matched or turned back down.
// Optional build macro: CARD_MISS_COUNT_EN -- when defined, 'misses' counts
// failed pairs (saturating at 255); when undefined, 'misses' is tied to 0.

module card_select_ctrl #(
  parameter int SHOW_CYCLES = 50000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_a,
  input  logic [4:0]  card_val,
  output logic [5:0]  rd_addr,
  output logic [5:0]  cursor,
  output logic [35:0] face_up,
  output logic [35:0] matched,
  output logic [4:0]  pairs_found,
  output logic        busy,
  output logic        game_over,
  output logic [7:0]  misses
);

  // The timer only ever holds SHOW_CYCLES-1 down to 0.
  localparam int TIMER_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] SHOW_LOAD = TIMER_W'(SHOW_CYCLES - 1);
  localparam logic [4:0] ALL_PAIRS = 5'd18;
  localparam logic [2:0] LAST_IDX  = 3'd5;

  // Button bit positions inside the packed button vector.
  localparam int NUM_BTN   = 5;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;

  typedef enum logic [2:0] {
    PICK1   = 3'd0,
    FETCH1  = 3'd1,
    PICK2   = 3'd2,
    FETCH2  = 3'd3,
    SHOW    = 3'd4,
    RESOLVE = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t state_reg;
  state_t state_next;

  // ---------------------------------------------------------------------------
  // Button edge detection
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_prev_reg;
  logic [NUM_BTN-1:0] btn_edge;
  logic               armed_reg;

  assign btn_level = {btn_a, btn_right, btn_left, btn_down, btn_up};

  // Previous button levels; armed_reg blanks edges on the first cycle out of
  // reset so a button held across reset release is not seen as a new press.
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_prev_reg <= '0;
      armed_reg    <= 1'b0;
    end else begin
      btn_prev_reg <= btn_level;
      armed_reg    <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_edge
      assign btn_edge[gi] = btn_level[gi] & ~btn_prev_reg[gi] & armed_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Cursor (kept as row/column so wrapping stays inside a row or column)
  // ---------------------------------------------------------------------------
  logic [2:0] row_reg;
  logic [2:0] row_next;
  logic [2:0] col_reg;
  logic [2:0] col_next;
  logic [5:0] row_ext;
  logic [5:0] cursor_pos;

  assign row_ext    = {3'b000, row_reg};
  assign cursor_pos = (row_ext << 2) + (row_ext << 1) + {3'b000, col_reg};
  assign cursor     = cursor_pos;

  // One step per edge, highest-priority direction only; frozen once the game is over.
  always_comb begin
    row_next = row_reg;
    col_next = col_reg;
    if (state_reg != DONE) begin
      if (btn_edge[BTN_UP]) begin
        row_next = (row_reg == 3'd0) ? LAST_IDX : row_reg - 3'd1;
      end else if (btn_edge[BTN_DOWN]) begin
        row_next = (row_reg == LAST_IDX) ? 3'd0 : row_reg + 3'd1;
      end else if (btn_edge[BTN_LEFT]) begin
        col_next = (col_reg == 3'd0) ? LAST_IDX : col_reg - 3'd1;
      end else if (btn_edge[BTN_RIGHT]) begin
        col_next = (col_reg == LAST_IDX) ? 3'd0 : col_reg + 3'd1;
      end
    end
  end

  // Cursor position register.
  always_ff @(posedge clock) begin
    if (reset) begin
      row_reg <= 3'd0;
      col_reg <= 3'd0;
    end else begin
      row_reg <= row_next;
      col_reg <= col_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Pick bookkeeping
  // ---------------------------------------------------------------------------
  logic [5:0]         addr1_reg;
  logic [5:0]         addr2_reg;
  logic [4:0]         val1_reg;
  logic [4:0]         val2_reg;
  logic [TIMER_W-1:0] timer_reg;
  logic [35:0]        face_up_reg;
  logic [35:0]        matched_reg;
  logic [4:0]         pairs_reg;
  logic [4:0]         pairs_inc;
  logic               sel_ok;
  logic               is_match;

  // A press only counts on a card that is neither already up nor already paired.
  assign sel_ok    = btn_edge[BTN_A] & ~matched_reg[cursor_pos] & ~face_up_reg[cursor_pos];
  assign is_match  = (val1_reg == val2_reg);
  assign pairs_inc = pairs_reg + 5'd1;

  // Capture both picked addresses and the values read back for them.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr1_reg <= 6'd0;
      addr2_reg <= 6'd0;
      val1_reg  <= 5'd0;
      val2_reg  <= 5'd0;
    end else begin
      if (state_reg == PICK1 && sel_ok) addr1_reg <= cursor_pos;
      if (state_reg == PICK2 && sel_ok) addr2_reg <= cursor_pos;
      if (state_reg == FETCH1)          val1_reg  <= card_val;
      if (state_reg == FETCH2)          val2_reg  <= card_val;
    end
  end

  // Show timer: loaded on the way into SHOW, counts down to zero while there.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer_reg <= '0;
    end else if (state_reg == FETCH2) begin
      timer_reg <= SHOW_LOAD;
    end else if (state_reg == SHOW && timer_reg != '0) begin
      timer_reg <= timer_reg - TIMER_W'(1);
    end
  end

  // Face-up flags: set by an accepted pick, both cleared when the pair resolves.
  always_ff @(posedge clock) begin
    if (reset) begin
      face_up_reg <= '0;
    end else begin
      case (state_reg)
        PICK1, PICK2: begin
          if (sel_ok) face_up_reg[cursor_pos] <= 1'b1;
        end
        RESOLVE: begin
          face_up_reg[addr1_reg] <= 1'b0;
          face_up_reg[addr2_reg] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Matched flags and pair count only change on a successful resolution.
  always_ff @(posedge clock) begin
    if (reset) begin
      matched_reg <= '0;
      pairs_reg   <= 5'd0;
    end else if (state_reg == RESOLVE && is_match) begin
      matched_reg[addr1_reg] <= 1'b1;
      matched_reg[addr2_reg] <= 1'b1;
      pairs_reg              <= pairs_inc;
    end
  end

`ifdef CARD_MISS_COUNT_EN
  logic [7:0] misses_reg;

  // Failed-pair counter, saturating so it never wraps back to a small number.
  always_ff @(posedge clock) begin
    if (reset) begin
      misses_reg <= 8'd0;
    end else if (state_reg == RESOLVE && !is_match && misses_reg != 8'hFF) begin
      misses_reg <= misses_reg + 8'd1;
    end
  end

  assign misses = misses_reg;
`else
  assign misses = 8'd0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= PICK1;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state plus state-decoded outputs (busy, game_over, read address).
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    game_over  = 1'b0;
    rd_addr    = addr2_reg;
    case (state_reg)
      PICK1: begin
        rd_addr = cursor_pos;
        if (sel_ok) state_next = FETCH1;
      end
      FETCH1: begin
        busy       = 1'b1;
        rd_addr    = addr1_reg;
        state_next = PICK2;
      end
      PICK2: begin
        rd_addr = cursor_pos;
        if (sel_ok) state_next = FETCH2;
      end
      FETCH2: begin
        busy       = 1'b1;
        state_next = SHOW;
      end
      SHOW: begin
        busy = 1'b1;
        if (timer_reg == '0) state_next = RESOLVE;
      end
      RESOLVE: begin
        busy = 1'b1;
        if (is_match && pairs_inc == ALL_PAIRS) state_next = DONE;
        else                                    state_next = PICK1;
      end
      DONE: begin
        game_over = 1'b1;
      end
      default: begin
        state_next = PICK1;
      end
    endcase
  end

  assign face_up     = face_up_reg;
  assign matched     = matched_reg;
  assign pairs_found = pairs_reg;

endmodule

// File: tb/tb_card_select_ctrl.sv
`timescale 1ns/1ps
// Testbench for card_select_ctrl: randomized play against a card-level game
// model, with expected output snapshots queued by the stimulus and compared by
// an independent monitor on the falling clock edge.

module tb_card_select_ctrl;

  localparam int SC = 4;
  localparam logic [4:0] B_UP = 5'b00001;
  localparam logic [4:0] B_DN = 5'b00010;
  localparam logic [4:0] B_LT = 5'b00100;
  localparam logic [4:0] B_RT = 5'b01000;
  localparam logic [4:0] B_A  = 5'b10000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  btns  = 5'd0;
  logic [4:0]  card_val = 5'd0;
  logic [5:0]  rd_addr;
  logic [5:0]  cursor;
  logic [35:0] face_up;
  logic [35:0] matched;
  logic [4:0]  pairs_found;
  logic        busy;
  logic        game_over;
  logic [7:0]  misses;

  always #5 clock = ~clock;

  // Card memory with one-cycle registered read.
  logic [4:0] mem [36];
  always @(posedge clock) card_val <= (rd_addr < 6'd36) ? mem[rd_addr] : 5'd31;

  card_select_ctrl #(.SHOW_CYCLES(SC)) dut (
    .clock       (clock),
    .reset       (reset),
    .btn_up      (btns[0]),
    .btn_down    (btns[1]),
    .btn_left    (btns[2]),
    .btn_right   (btns[3]),
    .btn_a       (btns[4]),
    .card_val    (card_val),
    .rd_addr     (rd_addr),
    .cursor      (cursor),
    .face_up     (face_up),
    .matched     (matched),
    .pairs_found (pairs_found),
    .busy        (busy),
    .game_over   (game_over),
    .misses      (misses)
  );

  // Game model: cursor as row/col, sets of face-up and matched cards.
  int          m_row, m_col, m_pairs, m_misses;
  logic [35:0] m_face, m_matched;
  logic        m_busy, m_over;

  typedef struct {
    string       name;
    logic [5:0]  cursor;
    logic [35:0] face;
    logic [35:0] matched;
    logic [4:0]  pairs;
    logic        busy;
    logic        over;
    logic [7:0]  misses;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [5:0] m_cursor();
    return 6'(m_row * 6 + m_col);
  endfunction

  task automatic expect_now(input string name);
    exp_t e;
    e.name    = name;
    e.cursor  = m_cursor();
    e.face    = m_face;
    e.matched = m_matched;
    e.pairs   = 5'(m_pairs);
    e.busy    = m_busy;
    e.over    = m_over;
    e.misses  = 8'(m_misses);
    exp_q.push_back(e);
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  always @(negedge clock) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (cursor !== mon_e.cursor || face_up !== mon_e.face || matched !== mon_e.matched ||
          pairs_found !== mon_e.pairs || busy !== mon_e.busy || game_over !== mon_e.over ||
          misses !== mon_e.misses) begin
        errors++;
        $display("FAIL %s: got cur=%0d face=%09h matched=%09h pairs=%0d busy=%b over=%b misses=%0d; want cur=%0d face=%09h matched=%09h pairs=%0d busy=%b over=%b misses=%0d",
                 mon_e.name, cursor, face_up, matched, pairs_found, busy, game_over, misses,
                 mon_e.cursor, mon_e.face, mon_e.matched, mon_e.pairs, mon_e.busy, mon_e.over, mon_e.misses);
      end else begin
        $display("ok   %s: cur=%0d pairs=%0d busy=%b over=%b", mon_e.name, cursor, pairs_found, busy, game_over);
      end
    end
  end

  task automatic cyc(input logic [4:0] m);
    btns = m;
    @(posedge clock);
    #1;
  endtask

  task automatic m_reset();
    m_row = 0; m_col = 0; m_pairs = 0; m_misses = 0;
    m_face = '0; m_matched = '0; m_busy = 1'b0; m_over = 1'b0;
  endtask

  task automatic m_move(input logic [4:0] m);
    if (m_over) return;
    if (m[0])      m_row = (m_row + 5) % 6;
    else if (m[1]) m_row = (m_row + 1) % 6;
    else if (m[2]) m_col = (m_col + 5) % 6;
    else if (m[3]) m_col = (m_col + 1) % 6;
  endtask

  task automatic press_move(input logic [4:0] m, input string name);
    cyc(m);
    m_move(m);
    cyc(5'd0);
    expect_now(name);
  endtask

  task automatic goto(input int target);
    int tr, tc;
    tr = target / 6;
    tc = target % 6;
    for (int i = 0; i < 12 && m_cursor() != 6'(target); i++) begin
      if (m_col != tc) press_move((((tc - m_col + 6) % 6) <= 3) ? B_RT : B_LT, "nav");
      else             press_move((((tr - m_row + 6) % 6) <= 3) ? B_DN : B_UP, "nav");
    end
  endtask

  task automatic do_reset(input logic [4:0] hold, input string name);
    btns  = hold;
    reset = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    m_reset();
    expect_now(name);
    cyc(hold);
    cyc(hold);
    cyc(5'd0);
    expect_now({name, " held"});
  endtask

  // Press A at the cursor; a second accepted pick is followed through SHOW and
  // RESOLVE. With poke set, the cursor moves and A is pressed during SHOW.
  task automatic press_a(input string name, input bit poke);
    int c, a;
    bit ok;
    c  = int'(m_cursor());
    ok = !m_over && !m_matched[c] && !m_face[c];
    if (!ok || m_face == '0) begin
      cyc(B_A);
      if (ok) begin
        m_face[c] = 1'b1;
        m_busy    = 1'b1;
      end
      expect_now({name, " a-edge"});
      m_busy = 1'b0;
      cyc(5'd0);
      expect_now(name);
    end else begin
      a = 0;
      for (int i = 0; i < 36; i++) if (m_face[i]) a = i;
      cyc(B_A);
      m_face[c] = 1'b1;
      m_busy    = 1'b1;
      expect_now({name, " fetch2"});
      cyc(5'd0);
      expect_now({name, " show-first"});
      if (poke) begin
        cyc(B_LT);
        m_move(B_LT);
        cyc(B_A);
        repeat (SC - 3) cyc(5'd0);
      end else begin
        repeat (SC - 1) cyc(5'd0);
      end
      expect_now({name, " show-last"});
      cyc(5'd0);
      expect_now({name, " resolve"});
      cyc(5'd0);
      if (mem[a] == mem[c]) begin
        m_matched[a] = 1'b1;
        m_matched[c] = 1'b1;
        m_pairs++;
      end else begin
`ifdef CARD_MISS_COUNT_EN
        if (m_misses < 255) m_misses++;
`endif
      end
      m_face = '0;
      m_busy = 1'b0;
      if (m_pairs == 18) m_over = 1'b1;
      expect_now({name, " result"});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: summary not reached within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] vals [36];
    logic [4:0] tmp;
    int j;

    m_reset();
    for (int i = 0; i < 36; i++) mem[i] = 5'd20;
    @(posedge clock); #1;

    // Reset with a button held across release, then cursor wrapping/priority.
    do_reset(B_RT, "reset");
    press_move(B_LT, "left from 0");
    press_move(B_RT, "right wrap");
    press_move(B_UP, "up from 0");
    press_move(B_DN, "down wrap");
    press_move(B_UP | B_RT, "up+right");
    press_move(B_DN | B_LT | B_RT, "down+left+right");
    press_move(B_LT | B_RT, "left+right");

    // Matching pair 0/7, A during SHOW, A on matched card, A twice on same card.
    mem[0] = 5'd3;
    mem[7] = 5'd3;
    do_reset(5'd0, "reset before match");
    press_a("pick 0", 1'b0);
    goto(7);
    press_a("pick 7", 1'b1);
    goto(0);
    press_a("A on matched 0", 1'b0);
    goto(1);
    press_a("pick 1", 1'b0);
    press_a("A on same card", 1'b0);
    goto(2);
    press_a("pick 2", 1'b0);

    // Mismatching pair 0/1.
    mem[0] = 5'd1;
    mem[1] = 5'd2;
    do_reset(5'd0, "reset before miss");
    press_a("pick 0 val1", 1'b0);
    press_move(B_RT, "to 1");
    press_a("pick 1 val2", 1'b0);

    // Random multi-button moves.
    repeat (40) press_move(5'($urandom_range(0, 15)), "rand move");

    // Full random game on a shuffled deck.
    for (int k = 0; k < 36; k++) vals[k] = 5'(k / 2);
    for (int k = 35; k > 0; k--) begin
      j = int'($urandom_range(0, k));
      tmp = vals[k]; vals[k] = vals[j]; vals[j] = tmp;
    end
    for (int k = 0; k < 36; k++) mem[k] = vals[k];
    do_reset(5'd0, "reset before game");
    for (int att = 0; att < 300 && !m_over; att++) begin
      int cand[$];
      int a, b;
      cand = {};
      for (int i = 0; i < 36; i++) if (!m_matched[i]) cand.push_back(i);
      a = cand[$urandom_range(0, cand.size() - 1)];
      b = -1;
      if ($urandom_range(0, 2) != 0)
        for (int i = 0; i < 36; i++) if (i != a && !m_matched[i] && mem[i] == mem[a]) b = i;
      while (b < 0 || b == a) b = cand[$urandom_range(0, cand.size() - 1)];
      goto(a);
      press_a("game pick1", 1'b0);
      goto(b);
      press_a("game pick2", 1'b0);
    end
    checks++;
    if (!m_over) begin
      errors++;
      $display("FAIL game complete: got %0d pairs, want 18", m_pairs);
    end
    press_move(B_RT, "done right");
    press_move(B_UP | B_LT, "done up+left");
    press_a("done A", 1'b0);

    // Reset in the middle of SHOW.
    do_reset(5'd0, "reset after game");
    goto(2);
    press_a("pre-reset pick", 1'b0);
    goto(3);
    cyc(B_A);
    cyc(5'd0);
    cyc(5'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    m_reset();
    expect_now("reset mid-show");
    cyc(5'd0);
    press_a("pick after reset", 1'b0);

    @(negedge clock); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
